// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - single-outstanding WISHBONE classic initiator with bus timeout
module wb_master_port #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_addr_i,
    input  logic          req_we_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [3:0]    req_be_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] to_cnt;
    logic          to_hit;
    logic          bus_term;
    logic          bus_err;

    assign req_ready_o = (state == IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        to_hit    = 1'b0;
        bus_term  = 1'b0;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                to_hit   = (TIMEOUT != 0) && (to_cnt == TO_LAST);
                bus_term = wb_ack_i || wb_err_i || to_hit;
                // A real ack in the same cycle as the timeout edge still counts as success.
                bus_err  = wb_err_i || (to_hit && !wb_ack_i);
                if (bus_term) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            to_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        wb_adr_o <= req_addr_i;
                        wb_we_o  <= req_we_i;
                        wb_dat_o <= req_wdata_i;
                        wb_sel_o <= req_be_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        to_cnt   <= '0;
                    end
                end
                BUS: begin
                    if (bus_term) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= bus_err;
                        rsp_rdata_o <= (bus_err || wb_we_o) ? '0 : wb_dat_i;
                    end else if (TIMEOUT != 0) begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_port.sv
// tb/tb_wb_master_port.sv - directed self-checking bench for wb_master_port
module tb_wb_master_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack, err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_master_port #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_we_i    (req_we),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .wb_cyc_o    (cyc),
        .wb_stb_o    (stb),
        .wb_we_o     (we),
        .wb_adr_o    (adr),
        .wb_dat_o    (dat_o),
        .wb_sel_o    (sel),
        .wb_dat_i    (dat_i),
        .wb_ack_i    (ack),
        .wb_err_i    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] be);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = w;
        req_wdata = d;
        req_be    = be;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b1; dat_i = '0; ack = 1'b0; err = 1'b0;
        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        tick();

        // 1: zero-wait write
        set_req(32'h4, 1'b1, 32'hA5, 4'b0001);
        ack = 1'b1; dat_i = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        check("t1_cyc", cyc, 1);
        check("t1_stb", stb, 1);
        check("t1_we", we, 1);
        check("t1_sel", sel, 4'b0001);
        check("t1_adr", adr, 32'h4);
        check("t1_dat", dat_o, 32'hA5);
        check("t1_req_ready_busy", req_ready, 0);
        tick();
        ack = 1'b0;
        check("t1_stb_drop", stb, 0);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_rdata", rsp_rdata, 0);
        tick();
        check("t1_rsp_done", rsp_valid, 0);
        check("t1_req_ready", req_ready, 1);

        // 2: read with 3 wait states
        set_req(32'h0, 1'b0, 32'h0, 4'b1111);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_stb_wait%0d", i), stb, 1);
            check($sformatf("t2_adr_wait%0d", i), adr, 32'h0);
            tick();
        end
        ack = 1'b1; dat_i = 32'h1234_5678;
        check("t2_stb_last", stb, 1);
        tick();
        ack = 1'b0;
        check("t2_stb_drop", stb, 0);
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("t2_rsp_err", rsp_err, 0);
        tick();

        // 3: error alone, then error together with ack
        for (int k = 0; k < 2; k++) begin
            set_req(32'h8, 1'b0, 32'h0, 4'b1111);
            tick();
            req_valid = 1'b0;
            err = 1'b1; ack = (k == 1); dat_i = 32'hFFFF_FFFF;
            tick();
            err = 1'b0; ack = 1'b0;
            check($sformatf("t3_rsp_valid%0d", k), rsp_valid, 1);
            check($sformatf("t3_rsp_err%0d", k), rsp_err, 1);
            check($sformatf("t3_rsp_rdata%0d", k), rsp_rdata, 0);
            tick();
        end

        // 4: silent slave, timeout after 8 BUS cycles
        set_req(32'hC, 1'b0, 32'h0, 4'b1111);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_stb_cyc%0d", i), stb, 1);
            tick();
        end
        check("t4_cyc_drop", cyc, 0);
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_err", rsp_err, 1);
        check("t4_rsp_rdata", rsp_rdata, 0);
        tick();

        // 5: response back-pressure with a second request pending
        rsp_ready = 1'b0;
        set_req(32'h10, 1'b1, 32'h77, 4'b1100);
        ack = 1'b1;
        tick();
        set_req(32'h20, 1'b0, 32'h0, 4'b1111);
        tick();
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_rsp_hold%0d", i), rsp_valid, 1);
            check($sformatf("t5_req_blocked%0d", i), req_ready, 0);
            check($sformatf("t5_cyc_idle%0d", i), cyc, 0);
            tick();
        end
        check("t5_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        check("t5_rsp_released", rsp_valid, 0);
        check("t5_req_ready", req_ready, 1);
        check("t5_no_early_cyc", cyc, 0);
        tick();
        req_valid = 1'b0;
        check("t5_second_cyc", cyc, 1);
        check("t5_second_adr", adr, 32'h20);
        check("t5_second_we", we, 0);
        ack = 1'b1; dat_i = 32'h55;
        tick();
        ack = 1'b0;
        check("t5_second_rdata", rsp_rdata, 32'h55);
        tick();

        // 6: reset in the middle of a bus cycle
        set_req(32'h30, 1'b0, 32'h0, 4'b1111);
        tick();
        req_valid = 1'b0;
        check("t6_cyc_before", cyc, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_cyc_async", cyc, 0);
        check("t6_stb_async", stb, 0);
        check("t6_rsp_async", rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_req_ready", req_ready, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t6_no_rsp", rsp_valid, 0);
        check("t6_no_cyc", cyc, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
